// File: rtl/fe_mul_seq.sv
// rtl/fe_mul_seq.sv - bit-serial (a*b) mod 2^255-19 multiplier, MSB-first double-and-add.
// Optional input reduction in LOAD enabled by FE_MUL_INPUT_REDUCE_EN.
module fe_mul_seq #(
  parameter int N = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] prod,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [N-1:0] P = {N{1'b1}} - N'(18);
  localparam logic [N:0]   P_EXT = {1'b0, P};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;

  logic [N:0]    dbl;
  logic [N:0]    dbl_sub;
  logic [N-1:0]  dbl_red;
  logic [N:0]    sum;
  logic [N:0]    sum_sub;
  logic [N-1:0]  sum_red;
  logic [N-1:0]  acc_next;

`ifdef FE_MUL_INPUT_REDUCE_EN
  // One comparator is time-shared: a is reduced in the first LOAD cycle, b in the second.
  logic          load_phase;
  logic [N-1:0]  red_in;
  logic [N-1:0]  red_out;

  always_comb begin
    red_in  = load_phase ? b_r : a_r;
    red_out = (red_in >= P) ? (red_in - P) : red_in;
  end
`endif

  // One double-and-add step; each stage stays in [0, P) via one conditional subtract.
  always_comb begin
    dbl      = {acc, 1'b0};
    dbl_sub  = dbl - P_EXT;
    dbl_red  = (dbl >= P_EXT) ? dbl_sub[N-1:0] : dbl[N-1:0];
    sum      = {1'b0, dbl_red} + {1'b0, a_r};
    sum_sub  = sum - P_EXT;
    sum_red  = (sum >= P_EXT) ? sum_sub[N-1:0] : sum[N-1:0];
    acc_next = b_r[cnt] ? sum_red : dbl_red;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = LOAD;
`ifdef FE_MUL_INPUT_REDUCE_EN
      LOAD: if (load_phase) state_next = RUN;
`else
      LOAD: state_next = RUN;
`endif
      RUN:  if (cnt == '0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
`ifdef FE_MUL_INPUT_REDUCE_EN
      load_phase <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
`ifdef FE_MUL_INPUT_REDUCE_EN
            load_phase <= 1'b0;
`endif
          end
        end
        LOAD: begin
`ifdef FE_MUL_INPUT_REDUCE_EN
          if (!load_phase) begin
            a_r        <= red_out;
            load_phase <= 1'b1;
          end else begin
            b_r        <= red_out;
            load_phase <= 1'b0;
            cnt        <= CW'(N - 1);
          end
`else
          cnt <= CW'(N - 1);
`endif
        end
        RUN: begin
          acc <= acc_next;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign prod = acc;

endmodule

// File: tb/tb_fe_mul_seq.sv
// tb/tb_fe_mul_seq.sv - directed and random checks of fe_mul_seq against a big-integer modular model.
module tb_fe_mul_seq;

  localparam int N = 255;
  localparam logic [N-1:0] P = {N{1'b1}} - N'(18);
`ifdef FE_MUL_INPUT_REDUCE_EN
  localparam int LAT = 258;
`else
  localparam int LAT = 257;
`endif
  localparam int NRAND = 150;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] prod;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  fe_mul_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .prod(prod), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [511:0] w;
    w = 512'(x) * 512'(y);
    return N'(w % 512'(P));
  endfunction

  function automatic logic [N-1:0] rand_fe();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    w[255] = 1'b0;
    if (w[N-1:0] >= P) w[N-1:0] = w[N-1:0] - P;
    return w[N-1:0];
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latency is counted in cycles, the handshake cycle being cycle 0.
  task automatic do_op(input logic [N-1:0] xa, input logic [N-1:0] xb, input string tag, input int hold);
    int lat;
    logic [N-1:0] exp;
    exp = ref_mul(xa, xb);
    out_ready = (hold == 0);
    lat = 0;
    while (!in_ready && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b1;
    a = xa;
    b = xb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = rand_fe();
    b = rand_fe();
    chk({tag, "_in_ready_low"}, N'(in_ready), N'(0));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 100) chk({tag, "_busy"}, N'(busy), N'(1));
    end while (!out_valid && lat < 400);
    chk({tag, "_latency"}, N'(lat), N'(LAT));
    chk({tag, "_prod"}, prod, exp);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, N'(out_valid), N'(1));
        chk({tag, "_hold_prod"}, prod, exp);
        chk({tag, "_hold_in_ready"}, N'(in_ready), N'(0));
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_idle_in_ready"}, N'(in_ready), N'(1));
    chk({tag, "_idle_valid"}, N'(out_valid), N'(0));
  endtask

  initial begin
    int cyc;
    int ov_seen;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    #1;
    chk("rst_out_valid", N'(out_valid), N'(0));
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_prod", prod, N'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", N'(in_ready), N'(1));

    do_op(N'(3), N'(7), "3x7", 0);
    do_op(N'(1) << 254, N'(2), "wrap", 0);
    do_op(P - 1'b1, P - 1'b1, "pm1sq", 0);
    do_op(N'(0), P - 1'b1, "zero_a", 0);
    do_op(P - 1'b1, N'(0), "zero_b", 0);
    do_op(N'(12345), N'(678), "stall", 20);

    // Abort mid-RUN: cycle 2 holds bit 254, so bit 100 is processed in cycle 156.
    in_valid = 1'b1;
    a = rand_fe();
    b = rand_fe();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (cyc = 1; cyc < 156; cyc++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", N'(out_valid), N'(0));
    chk("abort_busy", N'(busy), N'(0));
    chk("abort_prod", prod, N'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("abort_no_valid", N'(ov_seen), N'(0));
    do_op(N'(5), N'(5), "after_abort", 0);

`ifdef FE_MUL_INPUT_REDUCE_EN
    do_op(P + N'(5), N'(1), "reduce_in", 0);
`endif

    for (int k = 0; k < NRAND; k++) begin
      ra = rand_fe();
      rb = rand_fe();
      do_op(ra, rb, "rand", 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
